// File: rtl/cc_mux21_arbiter.sv
// cc_mux21_arbiter: round-robin arbiter driving a shared 2:1 mux into a registered valid/ready output stage
//   clock/reset : CC_MUX21_ARBITER_CLOCK_50, CC_MUX21_ARBITER_RESET_InLow (async, active-low)
//   requester 1 : req1Valid_In, req1Data_InBUS, req1Ready_Out
//   requester 2 : req2Valid_In, req2Data_InBUS, req2Ready_Out
//   output      : outValid_Out, outData_OutBUS, outReady_In
//   observation : select_Out (0 = requester 1, 1 = requester 2)
module cc_mux21_arbiter #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_BURSTMAX  = 4
) (
  input  logic                        CC_MUX21_ARBITER_CLOCK_50,
  input  logic                        CC_MUX21_ARBITER_RESET_InLow,
  input  logic                        CC_MUX21_ARBITER_req1Valid_In,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MUX21_ARBITER_req1Data_InBUS,
  output logic                        CC_MUX21_ARBITER_req1Ready_Out,
  input  logic                        CC_MUX21_ARBITER_req2Valid_In,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MUX21_ARBITER_req2Data_InBUS,
  output logic                        CC_MUX21_ARBITER_req2Ready_Out,
  output logic                        CC_MUX21_ARBITER_outValid_Out,
  output logic [NUMBER_DATAWIDTH-1:0] CC_MUX21_ARBITER_outData_OutBUS,
  input  logic                        CC_MUX21_ARBITER_outReady_In,
  output logic                        CC_MUX21_ARBITER_select_Out
);
  localparam int BW = $clog2(NUMBER_BURSTMAX + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(NUMBER_BURSTMAX);
  typedef enum logic [1:0] {IDLE, G1, G2} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, beat_inc;
  logic last2_q, last2_d;
  logic out_valid_q, out_valid_d;
  logic [NUMBER_DATAWIDTH-1:0] out_data_q, out_data_d, mux_out;
  logic v1, v2, can_load, on_g2, own_v, oth_v, xfer;
  assign v1 = CC_MUX21_ARBITER_req1Valid_In;
  assign v2 = CC_MUX21_ARBITER_req2Valid_In;
  assign on_g2 = state_q == G2;
  assign mux_out = on_g2 ? CC_MUX21_ARBITER_req2Data_InBUS : CC_MUX21_ARBITER_req1Data_InBUS;
  assign can_load = !out_valid_q | CC_MUX21_ARBITER_outReady_In;
  // own/other view of the requesters lets G1 and G2 share one transition description
  assign own_v = on_g2 ? v2 : v1;
  assign oth_v = on_g2 ? v1 : v2;
  assign xfer = (state_q != IDLE) & own_v & can_load;
  assign beat_inc = beat_q + BW'(1);
  assign CC_MUX21_ARBITER_req1Ready_Out = (state_q == G1) & can_load;
  assign CC_MUX21_ARBITER_req2Ready_Out = on_g2 & can_load;
  assign CC_MUX21_ARBITER_select_Out = on_g2;
  assign CC_MUX21_ARBITER_outValid_Out = out_valid_q;
  assign CC_MUX21_ARBITER_outData_OutBUS = out_data_q;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    last2_d = last2_q;
    if (state_q == IDLE) begin
      if (v1 | v2) state_d = (v1 & v2) ? (last2_q ? G1 : G2) : (v1 ? G1 : G2);
    end else if (!own_v) begin
      beat_d = '0;
      last2_d = on_g2;
      state_d = oth_v ? (on_g2 ? G1 : G2) : IDLE;
    end else if (xfer) begin
      beat_d = beat_inc;
      if (beat_inc == BEAT_MAX) begin
        beat_d = '0;
        // burst limit only hands over when the other side is actually waiting
        if (oth_v) begin
          state_d = on_g2 ? G1 : G2;
          last2_d = on_g2;
        end
      end
    end
    out_valid_d = xfer | (out_valid_q & !CC_MUX21_ARBITER_outReady_In);
    out_data_d = xfer ? mux_out : out_data_q;
  end
  always_ff @(posedge CC_MUX21_ARBITER_CLOCK_50 or negedge CC_MUX21_ARBITER_RESET_InLow) begin
    if (!CC_MUX21_ARBITER_RESET_InLow) begin
      state_q <= IDLE;
      beat_q <= '0;
      last2_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      last2_q <= last2_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_cc_mux21_arbiter.sv
// tb_cc_mux21_arbiter: directed-vector bench for cc_mux21_arbiter
module tb_cc_mux21_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, v1 = 1'b0, v2 = 1'b0, out_ready = 1'b0;
  logic [7:0] d1 = '0, d2 = '0, out_data;
  logic r1, r2, out_valid, sel;
  logic [7:0] b1, s1, b2, s2;
  int i1, i2;
  int vectors = 0, miscompares = 0;
  logic [7:0] exp_c [9] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4};
  logic exp_s [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  cc_mux21_arbiter dut (
    .CC_MUX21_ARBITER_CLOCK_50(clk),
    .CC_MUX21_ARBITER_RESET_InLow(rst_n),
    .CC_MUX21_ARBITER_req1Valid_In(v1),
    .CC_MUX21_ARBITER_req1Data_InBUS(d1),
    .CC_MUX21_ARBITER_req1Ready_Out(r1),
    .CC_MUX21_ARBITER_req2Valid_In(v2),
    .CC_MUX21_ARBITER_req2Data_InBUS(d2),
    .CC_MUX21_ARBITER_req2Ready_Out(r2),
    .CC_MUX21_ARBITER_outValid_Out(out_valid),
    .CC_MUX21_ARBITER_outData_OutBUS(out_data),
    .CC_MUX21_ARBITER_outReady_In(out_ready),
    .CC_MUX21_ARBITER_select_Out(sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    d1 = 8'(b1 + s1 * i1);
    d2 = 8'(b2 + s2 * i2);
  endtask
  task automatic tick();
    logic x1, x2;
    x1 = v1 & r1;
    x2 = v2 & r2;
    @(posedge clk);
    #1;
    if (x1) i1++;
    if (x2) i2++;
    drive();
  endtask
  task automatic restart(input logic [7:0] nb1, input logic [7:0] ns1, input logic [7:0] nb2, input logic [7:0] ns2);
    rst_n = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    out_ready = 1'b1;
    i1 = 0;
    i2 = 0;
    b1 = nb1; s1 = ns1; b2 = nb2; s2 = ns2;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_r1", r1, 0);
    chk("rst_r2", r2, 0);
    restart(8'h11, 8'h11, 8'h00, 8'h00);
    v1 = 1'b1;
    tick();
    chk("single_lat_valid", out_valid, 0);
    chk("single_lat_r1", r1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("single_data", out_data, 8'h11 * (k + 1));
      chk("single_sel", sel, 0);
    end
    v1 = 1'b0;
    tick();
    chk("single_drain_valid", out_valid, 0);
    chk("single_idle_r1", r1, 0);
    restart(8'hA0, 8'h01, 8'hB0, 8'h01);
    v1 = 1'b1;
    v2 = 1'b1;
    tick();
    chk("cont_first_r1", r1, 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("cont_data", out_data, exp_c[k]);
      chk("cont_sel", sel, exp_s[k]);
      chk("cont_valid", out_valid, 1);
    end
    restart(8'hC0, 8'h01, 8'hD0, 8'h01);
    v1 = 1'b1;
    v2 = 1'b1;
    tick();
    tick();
    chk("bp_first", out_data, 8'hC0);
    out_ready = 1'b0;
    #1;
    chk("bp_r1_low", r1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", out_data, 8'hC0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sel", sel, 0);
      chk("bp_r2_low", r2, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_r1_back", r1, 1);
    tick();
    chk("bp_c1", out_data, 8'hC1);
    tick();
    chk("bp_c2", out_data, 8'hC2);
    tick();
    chk("bp_c3", out_data, 8'hC3);
    chk("bp_switch_sel", sel, 1);
    tick();
    chk("bp_d0", out_data, 8'hD0);
    restart(8'h10, 8'h01, 8'h20, 8'h01);
    v1 = 1'b1;
    v2 = 1'b1;
    tick();
    tick();
    chk("drop_b0", out_data, 8'h10);
    tick();
    chk("drop_b1", out_data, 8'h11);
    v1 = 1'b0;
    tick();
    chk("drop_sel", sel, 1);
    chk("drop_r2", r2, 1);
    chk("drop_gap_valid", out_valid, 0);
    tick();
    chk("drop_req2", out_data, 8'h20);
    v2 = 1'b0;
    tick();
    chk("drop_idle_sel", sel, 0);
    chk("drop_idle_r2", r2, 0);
    v1 = 1'b1;
    v2 = 1'b1;
    tick();
    chk("drop_tie_sel", sel, 0);
    chk("drop_tie_r1", r1, 1);
    tick();
    chk("drop_tie_data", out_data, 8'h12);
    restart(8'h50, 8'h01, 8'h00, 8'h00);
    v1 = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("burst_data", out_data, 8'h50 + k);
      chk("burst_sel", sel, 0);
      chk("burst_valid", out_valid, 1);
    end
    restart(8'h00, 8'h00, 8'h60, 8'h01);
    v2 = 1'b1;
    tick();
    tick();
    chk("mid_pre_sel", sel, 1);
    chk("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    chk("mid_sel", sel, 0);
    chk("mid_r1", r1, 0);
    chk("mid_r2", r2, 0);
    v1 = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_after_sel", sel, 0);
    chk("mid_after_r1", r1, 1);
    chk("mid_after_r2", r2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cc_mux21_arbiter.md
Name: cc_mux21_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 datapath multiplexer (8-bit default).
- Two requesters each present data with a valid/ready handshake. The block grants one requester at a time and drives the mux select from its grant state.
- The multiplexed word is captured into a registered output stage with valid/ready toward the downstream consumer.
- The mux is instantiated internally; its select is also exported for observation.

Parameters:
- NUMBER_DATAWIDTH, 8, width of requester and output data words.
- NUMBER_BURSTMAX, 4, max consecutive beats granted to one requester while the other is waiting; legal range 1..255.

Ports:
- CC_MUX21_ARBITER_CLOCK_50  input  1  system clock, all state on rising edge.
- CC_MUX21_ARBITER_RESET_InLow  input  1  asynchronous, active-low reset.
- CC_MUX21_ARBITER_req1Valid_In  input  1  requester 1 has a word.
- CC_MUX21_ARBITER_req1Data_InBUS  input  NUMBER_DATAWIDTH  requester 1 word (mux data1).
- CC_MUX21_ARBITER_req1Ready_Out  output  1  requester 1 word accepted this cycle when high with valid.
- CC_MUX21_ARBITER_req2Valid_In  input  1  requester 2 has a word.
- CC_MUX21_ARBITER_req2Data_InBUS  input  NUMBER_DATAWIDTH  requester 2 word (mux data2).
- CC_MUX21_ARBITER_req2Ready_Out  output  1  requester 2 accept.
- CC_MUX21_ARBITER_outValid_Out  output  1  output register holds a word.
- CC_MUX21_ARBITER_outData_OutBUS  output  NUMBER_DATAWIDTH  registered output word.
- CC_MUX21_ARBITER_outReady_In  input  1  downstream accepts the output word.
- CC_MUX21_ARBITER_select_Out  output  1  mux select: 0 = requester 1, 1 = requester 2.

Behaviour:
- Reset is asynchronous and active-low. It is applied immediately and clears everything at once; an in-flight word is discarded, with no completion.
  - state = IDLE, last_served = 2 (requester 1 wins the first tie), beat_cnt = 0.
  - outValid = 0, outData = 0, select = 0.
  - Both ready outputs = 0.
- Signal definitions:
  - can_load = !outValid | outReady.
  - Transfer on requester k = reqkValid & reqkReady.
- FSM states: IDLE, G1, G2 (registered).
  - select = 1 only in G2, otherwise 0.
  - req1Ready = (state==G1) & can_load.
  - req2Ready = (state==G2) & can_load.
  - IDLE never accepts data.
- IDLE transitions, taking effect the next cycle:
  - Only req1Valid high -> G1.
  - Only req2Valid high -> G2.
  - Both high -> requester opposite to last_served.
  - Neither high -> stay in IDLE.
  - Minimum latency from first valid to first acceptance is 1 cycle.
- G1 transitions (G2 is symmetric with roles swapped):
  - Transfer: beat_cnt += 1.
  - Transfer making beat_cnt == NUMBER_BURSTMAX and req2Valid high -> G2, beat_cnt = 0, last_served = 1.
  - Transfer making beat_cnt == NUMBER_BURSTMAX and req2Valid low -> stay in G1, beat_cnt = 0.
  - req1Valid low -> beat_cnt = 0, last_served = 1; go to G2 if req2Valid, else IDLE.
  - req1Valid high but stalled (can_load = 0) -> hold state and beat_cnt.
- Grant-switch timing:
  - A switch takes effect the next cycle; there is no dead cycle between G1 and G2.
  - The select change and the new ready assert in the same cycle.
- Output register:
  - On a transfer, outData <= mux output and outValid <= 1.
  - Otherwise, if outReady, outValid <= 0 and outData holds its value.
  - Full throughput is 1 word/cycle when outReady is held high.
- beat_cnt width is clog2(NUMBER_BURSTMAX+1); it never exceeds NUMBER_BURSTMAX.
- Requester data is sampled only on a transfer. Valid dropping without a transfer is legal.

Test Plan:
- Reset mid-burst: assert reset while in G2 with outValid = 1 -> all outputs 0 immediately; after release, both valid -> G1 is granted first.
- Single requester: req1 streams 0x11, 0x22, 0x33 with outReady = 1 -> outData shows 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after first valid; select stays 0 throughout.
- Contention, NUMBER_BURSTMAX = 4: both valid continuously, req1 data 0xA0+n, req2 data 0xB0+n -> output sequence A0 A1 A2 A3 B0 B1 B2 B3 A4…; select toggles every 4 beats with no gap cycle.
- Backpressure: outReady = 0 for 3 cycles while in G1 -> req1Ready low, outData held, beat_cnt frozen; when outReady returns to 1, no word is lost or duplicated.
- Requester drops: req1 sends 2 beats then deasserts while req2 is valid -> G2 the next cycle with select = 1. When req2 goes idle and both later reassert, req1 wins the tie.
- Burst limit, no contention: req1 sends 10 beats with req2 idle -> stays in G1 the whole time; beat_cnt wraps 0..4 and never forces a switch or a bubble.
